// File: rtl/recorder_pkg.sv
// Shared constants for the recorder transport controller: state encoding,
// default widths and the sample-rate divider helper.
package recorder_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 2'd0,
        ST_RECORD    = 2'd1,
        ST_PLAY      = 2'd2,
        ST_PLAY_WAIT = 2'd3
    } state_e;

    localparam int unsigned DEF_CLK_HZ    = 100_000_000;
    localparam int unsigned DEF_SAMPLE_HZ = 8_000;
    localparam int unsigned DEF_ADDR_W    = 16;
    localparam int unsigned DEF_SAMPLE_W  = 12;

    // Clock cycles per audio sample.
    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/recorder_control_fsm_if.sv
// Sample-memory bus between the transport controller (master) and the memory (slave).
interface recorder_control_fsm_if
    import recorder_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
);
    logic [ADDR_W-1:0]   mem_addr;
    logic [SAMPLE_W-1:0] mem_wdata;
    logic                mem_we;
    logic                mem_re;
    logic [SAMPLE_W-1:0] mem_rdata;
    logic                mem_rvalid;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: counts 0..DIV-1 while enabled and pulses tick on the wrap.
// The count is held at zero while disabled and restarts on clear.
module sample_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int unsigned     CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_MAX);

    // Next count: restart on clear, disable or wrap.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || !en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/recorder_control_fsm.sv
// Recorder transport controller: turns debounced record/play/stop pulses into
// sample-rate memory writes (record) and memory-to-DAC streaming (playback).
// Optional build macro LOOP_PLAYBACK_EN: playback wraps to the first sample
// instead of stopping after the last one.
module recorder_control_fsm
    import recorder_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned SAMPLE_HZ = DEF_SAMPLE_HZ,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned SAMPLE_W  = DEF_SAMPLE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rec_btn_i,
    input  logic                  play_btn_i,
    input  logic                  stop_btn_i,
    input  logic [SAMPLE_W-1:0]   adc_sample_i,
    recorder_control_fsm_if.master mem,
    output logic [SAMPLE_W-1:0]   dac_sample_o,
    output logic                  dac_valid_o,
    output logic [ADDR_W:0]       rec_len_o,
    output logic [STATE_W-1:0]    state_o
);
    localparam int unsigned      TICK_DIV  = tick_div(CLK_HZ, SAMPLE_HZ);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rec_len_q, rec_len_d;
    logic [SAMPLE_W-1:0] dac_sample_q, dac_sample_d;
    logic                dac_valid_q, dac_valid_d;
    logic [ADDR_W:0]     addr_inc;
    logic                tick, tick_clear, we_c, re_c;

    // Playback position widened so it compares directly against rec_len.
    assign addr_inc = {1'b0, addr_q} + (ADDR_W + 1)'(1);

    // The divider keeps running across PLAY <-> PLAY_WAIT so the playback rate
    // stays locked; it restarts only when recording begins (IDLE holds it at 0).
    assign tick_clear = (state_d == ST_RECORD) && (state_q != ST_RECORD);

    sample_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .clear_i (tick_clear),
        .en_i    (state_q != ST_IDLE),
        .tick_o  (tick)
    );

    // Next-state, datapath updates and memory strobes.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rec_len_d    = rec_len_q;
        dac_sample_d = dac_sample_q;
        dac_valid_d  = 1'b0;
        we_c         = 1'b0;
        re_c         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (stop_btn_i) begin
                    state_d = ST_IDLE;
                end else if (rec_btn_i) begin
                    state_d = ST_RECORD;
                    addr_d  = '0;
                end else if (play_btn_i && (rec_len_q != '0)) begin
                    state_d = ST_PLAY;
                    addr_d  = '0;
                end
            end
            ST_RECORD: begin
                // A write due this cycle completes even when the recording ends.
                if (tick) begin
                    we_c   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (stop_btn_i || rec_btn_i || (tick && (addr_q == ADDR_LAST))) begin
                    state_d   = ST_IDLE;
                    rec_len_d = tick ? addr_inc : {1'b0, addr_q};
                end
            end
            ST_PLAY: begin
                if (stop_btn_i) begin
                    state_d = ST_IDLE;
                end else if (rec_btn_i) begin
                    state_d = ST_RECORD;
                    addr_d  = '0;
                end else if (tick) begin
                    re_c    = 1'b1;
                    state_d = ST_PLAY_WAIT;
                end
            end
            ST_PLAY_WAIT: begin
                // Ticks arriving here are dropped: the read has not returned yet.
                if (stop_btn_i) begin
                    state_d = ST_IDLE;
                end else if (rec_btn_i) begin
                    state_d = ST_RECORD;
                    addr_d  = '0;
                end else if (mem.mem_rvalid) begin
                    dac_sample_d = mem.mem_rdata;
                    dac_valid_d  = 1'b1;
                    addr_d       = addr_inc[ADDR_W-1:0];
                    state_d      = ST_PLAY;
                    if (addr_inc == rec_len_q) begin
`ifdef LOOP_PLAYBACK_EN
                        addr_d  = '0;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rec_len_q    <= '0;
            dac_sample_q <= '0;
            dac_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rec_len_q    <= rec_len_d;
            dac_sample_q <= dac_sample_d;
            dac_valid_q  <= dac_valid_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = we_c ? adc_sample_i : '0;
    assign mem.mem_we    = we_c;
    assign mem.mem_re    = re_c;
    assign dac_sample_o  = dac_sample_q;
    assign dac_valid_o   = dac_valid_q;
    assign rec_len_o     = rec_len_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_recorder_control_fsm.sv
// Self-checking bench for recorder_control_fsm (TICK_DIV=10, 8-sample memory).
// Expected write/read/DAC timing is derived from the sample-rate rules, not the FSM.
module tb_recorder_control_fsm;
    import recorder_pkg::*;

    localparam int AW    = 3;
    localparam int SW    = 12;
    localparam int DIV   = 10;
    localparam int DEPTH = 8;
`ifdef LOOP_PLAYBACK_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rec_btn = 1'b0, play_btn = 1'b0, stop_btn = 1'b0;
    logic [SW-1:0] adc_sample = '0;
    logic [SW-1:0] dac_sample;
    logic          dac_valid;
    logic [AW:0]   rec_len;
    logic [1:0]    state;

    recorder_control_fsm_if #(.ADDR_W(AW), .SAMPLE_W(SW)) mem_if ();

    recorder_control_fsm #(
        .CLK_HZ(80), .SAMPLE_HZ(8), .ADDR_W(AW), .SAMPLE_W(SW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rec_btn_i    (rec_btn),
        .play_btn_i   (play_btn),
        .stop_btn_i   (stop_btn),
        .adc_sample_i (adc_sample),
        .mem          (mem_if),
        .dac_sample_o (dac_sample),
        .dac_valid_o  (dac_valid),
        .rec_len_o    (rec_len),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Random ADC input, remembered per cycle for the reference model.
    logic [SW-1:0] adc_hist [int];
    always @(posedge clk) begin
        #1;
        adc_sample = SW'($urandom_range(0, 4095));
        adc_hist[cyc] = adc_sample;
    end

    // Memory model and bus monitor.
    logic [SW-1:0] mem_arr [DEPTH];
    int            mem_lat = 2;
    int            pend_cyc = -100000;
    logic [AW-1:0] pend_addr = '0;
    int            wr_cyc[$], rd_cyc[$], dv_cyc[$];
    logic [AW-1:0] wr_addr[$], rd_addr[$];
    logic [SW-1:0] wr_data[$], dv_data[$];
    int            both_cnt = 0;

    always @(posedge clk) begin
        #1;
        mem_if.mem_rvalid = 1'b0;
        if (cyc == pend_cyc + mem_lat) begin
            mem_if.mem_rvalid = 1'b1;
            mem_if.mem_rdata  = mem_arr[pend_addr];
        end
    end

    always @(negedge clk) begin
        if (mem_if.mem_we === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(mem_if.mem_addr);
            wr_data.push_back(mem_if.mem_wdata);
            mem_arr[mem_if.mem_addr] = mem_if.mem_wdata;
        end
        if (mem_if.mem_re === 1'b1) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(mem_if.mem_addr);
            pend_cyc  = cyc;
            pend_addr = mem_if.mem_addr;
        end
        if (mem_if.mem_we === 1'b1 && mem_if.mem_re === 1'b1) both_cnt++;
        if (dac_valid === 1'b1) begin
            dv_cyc.push_back(cyc);
            dv_data.push_back(dac_sample);
        end
    end

    // Reference model: what memory should hold and what playback should show.
    logic [SW-1:0] mdl_mem [DEPTH];
    int            mdl_len = 0;
    logic [SW-1:0] mdl_last_dac = '0;

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    // One-cycle button pulse; returns the cycle in which it was presented.
    task automatic pulse(input bit r, input bit p, input bit s, output int at);
        @(posedge clk); #1;
        rec_btn = r; play_btn = p; stop_btn = s; at = cyc;
        @(posedge clk); #1;
        rec_btn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++;
        if (state !== 2'd0 || rec_len !== '0 || dac_valid !== 1'b0 || dac_sample !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: state=%0d rec_len=%0d dac_valid=%b dac_sample=%0d, want 0",
                     state, rec_len, dac_valid, dac_sample);
        end
        n_cmp++;
        if (mem_if.mem_we !== 1'b0 || mem_if.mem_re !== 1'b0 || mem_if.mem_addr !== '0
            || mem_if.mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: we=%b re=%b addr=%0d wdata=%0d, want 0",
                     mem_if.mem_we, mem_if.mem_re, mem_if.mem_addr, mem_if.mem_wdata);
        end
    endtask

    task automatic test_play_empty();
        int p, rb;
        rb = rd_cyc.size();
        pulse(1'b0, 1'b1, 1'b0, p);
        n_cmp++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL play_empty_state: got %0d want 0", state);
        end
        wait_until(p + 2 * DIV);
        n_cmp++;
        if (rd_cyc.size() - rb !== 0) begin
            n_fail++;
            $display("FAIL play_empty_reads: got %0d want 0", rd_cyc.size() - rb);
        end
    endtask

    // Record, optionally stopped stop_after cycles after the record pulse (<=0: run to full).
    task automatic test_record(input int stop_after);
        int t, s, n, tk, wb, rb, bb;
        wb = wr_cyc.size(); rb = rd_cyc.size(); bb = both_cnt;
        pulse(1'b1, 1'b0, 1'b0, t);
        if (stop_after > 0) begin
            wait_until(t + stop_after - 1);
            pulse(1'b0, 1'b0, 1'b1, s);
        end else begin
            s = t + 100000;
        end
        n = (s - t) / DIV;
        if (n > DEPTH) n = DEPTH;
        wait_until(t + DIV * DEPTH + 5);
        if (stop_after > 0) wait_until(s + 3);
        n_cmp++;
        if (wr_cyc.size() - wb !== n) begin
            n_fail++;
            $display("FAIL rec_nwrites: got %0d want %0d", wr_cyc.size() - wb, n);
        end
        for (int k = 0; k < n; k++) begin
            tk = t + DIV * (k + 1);
            mdl_mem[k] = adc_hist[tk];
            if (wb + k < wr_cyc.size()) begin
                n_cmp++;
                if (wr_cyc[wb+k] !== tk || wr_addr[wb+k] !== AW'(k)
                    || wr_data[wb+k] !== mdl_mem[k]) begin
                    n_fail++;
                    $display("FAIL rec_write%0d: cyc=%0d addr=%0d data=%0d want cyc=%0d addr=%0d data=%0d",
                             k, wr_cyc[wb+k] - t, wr_addr[wb+k], wr_data[wb+k],
                             tk - t, k, mdl_mem[k]);
                end
            end
        end
        mdl_len = n;
        n_cmp++;
        if (rec_len !== (AW + 1)'(n) || state !== 2'd0) begin
            n_fail++;
            $display("FAIL rec_end: rec_len=%0d state=%0d want rec_len=%0d state=0",
                     rec_len, state, n);
        end
        n_cmp++;
        if (rd_cyc.size() - rb !== 0 || both_cnt - bb !== 0) begin
            n_fail++;
            $display("FAIL rec_no_reads: reads=%0d both=%0d want 0",
                     rd_cyc.size() - rb, both_cnt - bb);
        end
    endtask

    // Play with read latency lat; stop pulse stop_after cycles after the play pulse.
    task automatic test_playback(input int lat, input int stop_after);
        int p, s, last_re, idx, rb, db, wb;
        int            e_rc[$], e_dc[$];
        logic [AW-1:0] e_ra[$];
        logic [SW-1:0] e_dd[$];
        mem_lat = lat;
        rb = rd_cyc.size(); db = dv_cyc.size(); wb = wr_cyc.size();
        pulse(1'b0, 1'b1, 1'b0, p);
        wait_until(p + stop_after - 1);
        pulse(1'b0, 1'b0, 1'b1, s);
        wait_until(s + lat + 5);
        // A read goes out on each sample tick that finds the previous read answered.
        last_re = -100000;
        idx = 0;
        for (int tt = p + DIV; tt < s; tt += DIV) begin
            if (mdl_len == 0 || (!LOOP_EN && idx == mdl_len)) break;
            if (tt > last_re + lat) begin
                e_rc.push_back(tt);
                e_ra.push_back(AW'(idx % mdl_len));
                if (tt + lat < s) begin
                    e_dc.push_back(tt + lat + 1);
                    e_dd.push_back(mdl_mem[idx % mdl_len]);
                    mdl_last_dac = mdl_mem[idx % mdl_len];
                end
                last_re = tt;
                idx++;
            end
        end
        n_cmp++;
        if (rd_cyc.size() - rb !== e_rc.size()) begin
            n_fail++;
            $display("FAIL play_nreads: got %0d want %0d", rd_cyc.size() - rb, e_rc.size());
        end
        for (int k = 0; k < e_rc.size() && rb + k < rd_cyc.size(); k++) begin
            n_cmp++;
            if (rd_cyc[rb+k] !== e_rc[k] || rd_addr[rb+k] !== e_ra[k]) begin
                n_fail++;
                $display("FAIL play_read%0d: cyc=%0d addr=%0d want cyc=%0d addr=%0d",
                         k, rd_cyc[rb+k] - p, rd_addr[rb+k], e_rc[k] - p, e_ra[k]);
            end
        end
        n_cmp++;
        if (dv_cyc.size() - db !== e_dc.size()) begin
            n_fail++;
            $display("FAIL play_ndac: got %0d want %0d", dv_cyc.size() - db, e_dc.size());
        end
        for (int k = 0; k < e_dc.size() && db + k < dv_cyc.size(); k++) begin
            n_cmp++;
            if (dv_cyc[db+k] !== e_dc[k] || dv_data[db+k] !== e_dd[k]) begin
                n_fail++;
                $display("FAIL play_dac%0d: cyc=%0d data=%0d want cyc=%0d data=%0d",
                         k, dv_cyc[db+k] - p, dv_data[db+k], e_dc[k] - p, e_dd[k]);
            end
        end
        n_cmp++;
        if (state !== 2'd0 || rec_len !== (AW + 1)'(mdl_len) || dac_sample !== mdl_last_dac
            || wr_cyc.size() - wb !== 0) begin
            n_fail++;
            $display("FAIL play_end: state=%0d rec_len=%0d dac=%0d writes=%0d want 0/%0d/%0d/0",
                     state, rec_len, dac_sample, wr_cyc.size() - wb, mdl_len, mdl_last_dac);
        end
    endtask

    task automatic test_idle_buttons();
        int t, wb;
        wb = wr_cyc.size();
        pulse(1'b1, 1'b0, 1'b1, t);
        wait_until(t + DIV + 5);
        n_cmp++;
        if (state !== 2'd0 || wr_cyc.size() - wb !== 0 || rec_len !== (AW + 1)'(mdl_len)) begin
            n_fail++;
            $display("FAIL idle_rec_stop: state=%0d writes=%0d rec_len=%0d want 0/0/%0d",
                     state, wr_cyc.size() - wb, rec_len, mdl_len);
        end
    endtask

    task automatic test_reset_mid_record();
        int t, p;
        pulse(1'b1, 1'b0, 1'b0, t);
        wait_until(t + 24);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        mdl_len = 0;
        mdl_last_dac = '0;
        n_cmp++;
        if (state !== 2'd0 || rec_len !== '0 || dac_valid !== 1'b0 || dac_sample !== '0
            || mem_if.mem_we !== 1'b0 || mem_if.mem_re !== 1'b0 || mem_if.mem_addr !== '0) begin
            n_fail++;
            $display("FAIL mid_rec_reset: state=%0d rec_len=%0d dv=%b dac=%0d we=%b re=%b addr=%0d",
                     state, rec_len, dac_valid, dac_sample, mem_if.mem_we, mem_if.mem_re,
                     mem_if.mem_addr);
        end
        pulse(1'b0, 1'b1, 1'b0, p);
        n_cmp++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_rec_play_ignored: state=%0d want 0", state);
        end
    endtask

    initial begin
        test_reset();
        test_play_empty();
        test_record(35);                        // three writes then stop
        test_playback(2, 30 * mdl_len + 35);
        test_idle_buttons();
        test_record(20);                        // stop lands on the second tick
        test_playback(2, 11);                   // stop while the read is outstanding
        test_record(0);                         // run to full
        test_playback(15, 30 * mdl_len + 35);   // slow memory: ticks dropped
        repeat (4) begin
            test_record(int'($urandom_range(2, 95)));
            test_playback(int'($urandom_range(1, 25)), 30 * mdl_len + 35);
        end
        test_reset_mid_record();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
